twiddle_mult: RTL

//  Twiddle-side consumer of the R2^2 SDF twiddle ROM (Twiddle). Counts incoming samples of one SDF stage,

---
 rtl/r22sdf_pkg.sv | 32 +++
 rtl/twiddle_mult_if.sv | 25 ++
 rtl/twiddle_mult_cmul_pipe.sv | 81 ++++++++
 rtl/twiddle_mult.sv | 69 ++++++
 4 files changed

// File: rtl/r22sdf_pkg.sv
// Shared R2^2 SDF definitions: default sizes, complex sample type, saturation and twiddle index helpers.
package r22sdf_pkg;

    localparam int DEF_LOG_N = 7;
    localparam int DEF_WIDTH = 16;

    typedef struct packed {
        logic signed [DEF_WIDTH-1:0] re;
        logic signed [DEF_WIDTH-1:0] im;
    } cplx_t;

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic longint sat_w(input longint x, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (x > hi)      return hi;
        else if (x < lo) return lo;
        else             return x;
    endfunction

    // sel walks 0,2,1,3 across the four quarters of the span (bit-reversed quarter index).
    function automatic int tw_index(input int cnt, input int log_n, input int log_m);
        int sel;
        int num;
        sel = (((cnt >> (log_m - 2)) & 1) << 1) | ((cnt >> (log_m - 1)) & 1);
        num = (cnt & ((1 << (log_m - 2)) - 1)) << (log_n - log_m);
        return (num * sel) & ((1 << log_n) - 1);
    endfunction

endpackage

// File: rtl/twiddle_mult_if.sv
// Sample stream in/out plus the twiddle ROM address/data pair of one SDF stage.
interface twiddle_mult_if #(
    parameter int LOG_N = 7,
    parameter int WIDTH = 16
) ();
    logic                    di_en;
    logic signed [WIDTH-1:0] di_re;
    logic signed [WIDTH-1:0] di_im;
    logic [LOG_N-1:0]        tw_addr;
    logic signed [WIDTH-1:0] tw_re;
    logic signed [WIDTH-1:0] tw_im;
    logic                    do_en;
    logic signed [WIDTH-1:0] do_re;
    logic signed [WIDTH-1:0] do_im;

    modport master (
        output di_en, di_re, di_im, tw_re, tw_im,
        input  tw_addr, do_en, do_re, do_im
    );

    modport slave (
        input  di_en, di_re, di_im, tw_re, tw_im,
        output tw_addr, do_en, do_re, do_im
    );
endinterface

// File: rtl/twiddle_mult_cmul_pipe.sv
// Two-stage complex multiplier (products, then add/scale/saturate) with bypass for the "no multiply" address.
// TWIDDLE_ROUND_EN selects round-half-up before scaling; otherwise the result is floor-truncated.
module cmul_pipe
    import r22sdf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_en,
    input  logic                    in_byp,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    input  logic signed [WIDTH-1:0] tw_re,
    input  logic signed [WIDTH-1:0] tw_im,
    output logic                    out_en,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im
);
    localparam int PW     = 2 * WIDTH;
    localparam int SW     = 2 * WIDTH + 1;
    localparam int STAGES = 2;

    logic [STAGES:1]         vld_pipe;
    logic signed [PW-1:0]    rr, ii, ri, ir;
    logic                    byp1;
    logic signed [WIDTH-1:0] b_re, b_im;
    logic signed [SW-1:0]    s_re, s_im;

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_pipe <= '0;
            rr       <= '0;
            ii       <= '0;
            ri       <= '0;
            ir       <= '0;
            byp1     <= 1'b0;
            b_re     <= '0;
            b_im     <= '0;
        end else begin
            vld_pipe[1] <= in_en;
            vld_pipe[2] <= vld_pipe[1];
            if (in_en) begin
                rr   <= PW'(in_re) * PW'(tw_re);
                ii   <= PW'(in_im) * PW'(tw_im);
                ri   <= PW'(in_re) * PW'(tw_im);
                ir   <= PW'(in_im) * PW'(tw_re);
                byp1 <= in_byp;
                b_re <= in_re;
                b_im <= in_im;
            end
        end
    end

`ifdef TWIDDLE_ROUND_EN
    localparam logic signed [SW-1:0] RND = SW'(1) <<< (WIDTH - 2);
`endif

    always_comb begin
        s_re = SW'(rr) - SW'(ii);
        s_im = SW'(ri) + SW'(ir);
`ifdef TWIDDLE_ROUND_EN
        s_re = s_re + RND;
        s_im = s_im + RND;
`endif
    end

    // Output registers only move on valid results so idle cycles hold the last sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_re <= '0;
            out_im <= '0;
        end else if (vld_pipe[1]) begin
            out_re <= byp1 ? b_re : WIDTH'(sat_w(longint'(s_re >>> (WIDTH - 1)), WIDTH));
            out_im <= byp1 ? b_im : WIDTH'(sat_w(longint'(s_im >>> (WIDTH - 1)), WIDTH));
        end
    end

    assign out_en = vld_pipe[STAGES];

endmodule

// File: rtl/twiddle_mult.sv
// Twiddle-side consumer of the SDF twiddle ROM: sample counter, ROM addressing, data/ROM alignment and multiply.
// Build option TWIDDLE_ROUND_EN (see cmul_pipe) switches scaling from truncation to round-half-up.
module twiddle_mult
    import r22sdf_pkg::*;
#(
    parameter int LOG_N = DEF_LOG_N,
    parameter int LOG_M = 7,
    parameter int WIDTH = DEF_WIDTH,
    parameter int TW_FF = 1
) (
    input logic           clock,
    input logic           reset,
    twiddle_mult_if.slave bus
);
    logic [LOG_N-1:0]        cnt;
    logic                    byp;
    logic                    a_en;
    logic                    a_byp;
    logic signed [WIDTH-1:0] a_re, a_im;

    always_ff @(posedge clock) begin
        if (reset)           cnt <= '0;
        else if (bus.di_en)  cnt <= cnt + 1'b1;
    end

    assign bus.tw_addr = LOG_N'(tw_index(int'(cnt), LOG_N, LOG_M));
    assign byp         = (bus.tw_addr == '0);

    // Data waits here for the ROM read so both reach the multiplier together.
    if (TW_FF != 0) begin : g_align_ff
        always_ff @(posedge clock) begin
            if (reset) begin
                a_en  <= 1'b0;
                a_byp <= 1'b0;
                a_re  <= '0;
                a_im  <= '0;
            end else begin
                a_en <= bus.di_en;
                if (bus.di_en) begin
                    a_byp <= byp;
                    a_re  <= bus.di_re;
                    a_im  <= bus.di_im;
                end
            end
        end
    end else begin : g_align_comb
        always_comb begin
            a_en  = bus.di_en;
            a_byp = byp;
            a_re  = bus.di_re;
            a_im  = bus.di_im;
        end
    end

    cmul_pipe #(.WIDTH(WIDTH)) u_cmul (
        .clock  (clock),
        .reset  (reset),
        .in_en  (a_en),
        .in_byp (a_byp),
        .in_re  (a_re),
        .in_im  (a_im),
        .tw_re  (bus.tw_re),
        .tw_im  (bus.tw_im),
        .out_en (bus.do_en),
        .out_re (bus.do_re),
        .out_im (bus.do_im)
    );

endmodule
